// File: rtl/mont_mul_param.sv
// -----------------------------------------------------------------------------
// mont_mul_param
//
// Parametrised Montgomery modular multiplier for the RSA datapath.
// Computes o_result = a * b * 2^(-WIDTH) mod n using radix-2 iterations.
// BPC radix-2 steps are unrolled per clock, so a legal operation takes
// WIDTH/BPC CALC cycles plus one FINAL cycle.
//
// Parameters
//   WIDTH : operand/modulus width in bits (multiple of BPC, >= 4)
//   BPC   : radix-2 iterations per clock (1, 2 or 4)
//
// Ports
//   i_clk    : clock, all logic on the rising edge
//   i_rst    : synchronous active-high reset, aborts any operation
//   i_start  : start request, only looked at in IDLE
//   i_n      : modulus, must be odd (and therefore nonzero)
//   i_a      : multiplicand, must be < i_n
//   i_b      : multiplier, must be < i_n
//   o_result : Montgomery product, held until the next completion
//   o_done   : one-cycle completion pulse
//   o_busy   : high from the cycle after an accepted start until o_done
//   o_err    : qualifies o_done; illegal operands, o_result forced to 0
// -----------------------------------------------------------------------------
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for i_start; latches operands and checks legality
// S_CALC  | WIDTH/BPC cycles of BPC radix-2 steps each, a LSB first
// S_FINAL | conditional subtract of n, publish result, pulse o_done
// S_ERR   | illegal operands: o_result=0, pulse o_done with o_err
// -----------------------------------------------------------------------------
module mont_mul_param #(
    parameter int WIDTH = 256,
    parameter int BPC   = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_n,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_done,
    output logic             o_busy,
    output logic             o_err
);

    localparam int ITERS = WIDTH / BPC;
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    // Two spare bits: m < 2n holds between steps, and m + b + n < 4n.
    localparam int ACC_W = WIDTH + 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FINAL = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   n_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [ACC_W-1:0]   m_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   result_q;
    logic               done_q;
    logic               busy_q;
    logic               err_q;

    logic [ACC_W-1:0]   m_d;
    logic [WIDTH-1:0]   a_d;
    logic [ACC_W-1:0]   m_red_d;
    logic               legal_d;

    // BPC chained radix-2 steps; a is shifted so bit 0 is always the next bit.
    always_comb begin
        m_d = m_q;
        a_d = a_q;
        for (int i = 0; i < BPC; i++) begin
            if (a_d[0]) begin
                m_d = m_d + {2'b00, b_q};
            end
            if (m_d[0]) begin
                m_d = m_d + {2'b00, n_q};
            end
            m_d = m_d >> 1;
            a_d = a_d >> 1;
        end
    end

    // Single conditional subtraction suffices because m < 2n after CALC.
    always_comb begin
        m_red_d = m_q;
        if (m_q >= {2'b00, n_q}) begin
            m_red_d = m_q - {2'b00, n_q};
        end
    end

    // Even n also covers n == 0.
    assign legal_d = i_n[0] && (i_a < i_n) && (i_b < i_n);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        n_q    <= i_n;
                        a_q    <= i_a;
                        b_q    <= i_b;
                        m_q    <= '0;
                        cnt_q  <= CNT_LAST;
                        busy_q <= 1'b1;
                        state_q <= legal_d ? S_CALC : S_ERR;
                    end
                end
                S_CALC: begin
                    m_q <= m_d;
                    a_q <= a_d;
                    if (cnt_q == '0) begin
                        state_q <= S_FINAL;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_FINAL: begin
                    m_q      <= m_red_d;
                    result_q <= m_red_d[WIDTH-1:0];
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                S_ERR: begin
                    result_q <= '0;
                    err_q    <= 1'b1;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_result = result_q;
    assign o_done   = done_q;
    assign o_busy   = busy_q;
    assign o_err    = err_q;

endmodule

// File: tb/tb_mont_mul_param.sv
// -----------------------------------------------------------------------------
// tb_mont_mul_param
//
// Directed bench for mont_mul_param. Four instances share one clock/reset:
//   0: WIDTH=8   BPC=1      1: WIDTH=8   BPC=2
//   2: WIDTH=256 BPC=1      3: WIDTH=256 BPC=4
// Latency is counted the way the block is specified: the edge that samples
// i_start is edge 0, and o_done raised by edge k is reported as k+1.
// Wide vectors use moduli with easy inverses of R=2^256:
//   n = 2^256-1 : R = 1 mod n, so the product is a*b mod n
//   n = 2^255+1 : R^-1 = 2^254 mod n
// -----------------------------------------------------------------------------
module tb_mont_mul_param;

    logic clk;
    logic rst;
    logic [3:0] start_v;
    logic [7:0] n8, a8, b8;
    logic [255:0] n256, a256, b256;

    logic [7:0]   r0, r1;
    logic [255:0] r2, r3;
    logic d0, d1, d2, d3;
    logic y0, y1, y2, y3;
    logic e0, e1, e2, e3;

    logic         done_v [4];
    logic         busy_v [4];
    logic         err_v  [4];
    logic [255:0] res_v  [4];

    int checks;
    int failures;

    mont_mul_param #(.WIDTH(8), .BPC(1)) u_w8_b1 (
        .i_clk(clk), .i_rst(rst), .i_start(start_v[0]),
        .i_n(n8), .i_a(a8), .i_b(b8),
        .o_result(r0), .o_done(d0), .o_busy(y0), .o_err(e0));

    mont_mul_param #(.WIDTH(8), .BPC(2)) u_w8_b2 (
        .i_clk(clk), .i_rst(rst), .i_start(start_v[1]),
        .i_n(n8), .i_a(a8), .i_b(b8),
        .o_result(r1), .o_done(d1), .o_busy(y1), .o_err(e1));

    mont_mul_param #(.WIDTH(256), .BPC(1)) u_w256_b1 (
        .i_clk(clk), .i_rst(rst), .i_start(start_v[2]),
        .i_n(n256), .i_a(a256), .i_b(b256),
        .o_result(r2), .o_done(d2), .o_busy(y2), .o_err(e2));

    mont_mul_param #(.WIDTH(256), .BPC(4)) u_w256_b4 (
        .i_clk(clk), .i_rst(rst), .i_start(start_v[3]),
        .i_n(n256), .i_a(a256), .i_b(b256),
        .o_result(r3), .o_done(d3), .o_busy(y3), .o_err(e3));

    always_comb begin
        done_v[0] = d0; done_v[1] = d1; done_v[2] = d2; done_v[3] = d3;
        busy_v[0] = y0; busy_v[1] = y1; busy_v[2] = y2; busy_v[3] = y3;
        err_v[0]  = e0; err_v[1]  = e1; err_v[2]  = e2; err_v[3]  = e3;
        res_v[0]  = {248'b0, r0};
        res_v[1]  = {248'b0, r1};
        res_v[2]  = r2;
        res_v[3]  = r3;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [255:0] n, input logic [255:0] a, input logic [255:0] b);
        n8 = n[7:0];  a8 = a[7:0];  b8 = b[7:0];
        n256 = n;     a256 = a;     b256 = b;
    endtask

    // Launches from the current (mid-cycle) point, waits for o_done with a
    // cycle budget and returns #1 after the edge that raised o_done.
    task automatic op(input int sel, input logic [255:0] n, input logic [255:0] a,
                      input logic [255:0] b, input bit hold,
                      input logic [255:0] exp_res, input logic exp_err,
                      input int exp_lat, input string tag);
        int cyc;
        int busy_n;
        bit seen;
        drive(n, a, b);
        start_v[sel] = 1'b1;
        @(posedge clk); #1;
        if (hold) drive(256'd12, 256'd9, 256'd2);
        else start_v[sel] = 1'b0;
        cyc = 0; busy_n = 0; seen = 1'b0;
        while (!seen && cyc < 400) begin
            if (busy_v[sel]) busy_n++;
            @(posedge clk); #1;
            cyc++;
            if (done_v[sel]) seen = 1'b1;
        end
        start_v[sel] = 1'b0;
        chk({tag, "/latency"}, seen ? 256'(cyc + 1) : '1, 256'(exp_lat));
        chk({tag, "/result"}, res_v[sel], exp_res);
        chk({tag, "/err"}, {255'b0, err_v[sel]}, {255'b0, exp_err});
        chk({tag, "/busy_cycles"}, 256'(busy_n), 256'(exp_lat - 1));
        chk({tag, "/busy_in_done"}, {255'b0, busy_v[sel]}, 256'd0);
    endtask

    logic [255:0] n_all1;
    logic [255:0] n_p255;
    logic [255:0] v_tmp;

    initial begin
        int dn;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        start_v = 4'b0;
        drive('0, '0, '0);
        n_all1 = '1;
        n_p255 = {1'b1, 254'b0, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_flags%0d", i), {253'b0, done_v[i], busy_v[i], err_v[i]}, 256'd0);
            chk($sformatf("reset_result%0d", i), res_v[i], 256'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Test 1: W8 BPC1, 5*7*R^-1 mod 13 = 35*3 mod 13 = 1
        op(0, 256'd13, 256'd5, 256'd7, 1'b0, 256'd1, 1'b0, 10, "t1");
        @(posedge clk); #1;
        chk("t1/done_pulse", {255'b0, done_v[0]}, 256'd0);
        chk("t1/result_held", res_v[0], 256'd1);

        // Test 5: reset at cycle 4 of an operation aborts it
        drive(256'd13, 256'd5, 256'd7);
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5/flags_after_rst", {253'b0, done_v[0], busy_v[0], err_v[0]}, 256'd0);
        chk("t5/result_after_rst", res_v[0], 256'd0);
        dn = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done_v[0]) dn++;
        end
        chk("t5/no_done", 256'(dn), 256'd0);
        op(0, 256'd13, 256'd5, 256'd7, 1'b0, 256'd1, 1'b0, 10, "t5_fresh");

        // Test 2: W8 BPC2; R^-1 mod 13 = 3; n=255 gives R = 1, (-1)^2 = 1
        op(1, 256'd13, 256'd1, 256'd1, 1'b0, 256'd3, 1'b0, 6, "t2a");
        op(1, 256'd255, 256'd254, 256'd254, 1'b0, 256'd1, 1'b0, 6, "t2b");

        // Test 3: illegal operands (even n, then a == n)
        op(0, 256'd12, 256'd3, 256'd5, 1'b0, 256'd0, 1'b1, 2, "t3a");
        op(0, 256'd13, 256'd13, 256'd1, 1'b0, 256'd0, 1'b1, 2, "t3b");

        // Test 4: i_start held through busy, then back-to-back start on o_done
        op(0, 256'd13, 256'd5, 256'd7, 1'b1, 256'd1, 1'b0, 10, "t4a");
        op(0, 256'd13, 256'd0, 256'd7, 1'b0, 256'd0, 1'b0, 10, "t4b");

        // Test 6: 256-bit vectors on BPC=1 (latency 258) and BPC=4 (66)
        for (int s = 2; s < 4; s++) begin
            int lat;
            lat = (s == 2) ? 258 : 66;
            op(s, n_all1, 256'd2, 256'd3, 1'b0, 256'd6, 1'b0, lat, $sformatf("t6a_s%0d", s));
            v_tmp = n_all1 - 256'd1;
            op(s, n_all1, v_tmp, v_tmp, 1'b0, 256'd1, 1'b0, lat, $sformatf("t6b_s%0d", s));
            v_tmp = {1'b0, {255{1'b1}}};
            op(s, n_p255, 256'd2, 256'd2, 1'b0, v_tmp, 1'b0, lat, $sformatf("t6c_s%0d", s));
            v_tmp = 256'd1 << 254;
            op(s, n_p255, 256'd1, 256'd1, 1'b0, v_tmp, 1'b0, lat, $sformatf("t6d_s%0d", s));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
